wb_ram_slave: RTL and testbench
===============================

# wb_ram_slave

Wishbone classic-cycle responder backed by a synchronous single-port word RAM, with byte-lane write enables and a programmable wait-state count. It terminates one slave port of the Wishbone crossbar and gives the interconnect a real target for instruction and data traffic. It also serves as the reference responder for crossbar and master verification.

## Interface
Parameters:
- adr_width, 32, byte address width of wb_adr
- dat_width, 32, data bus width; must be a multiple of 8
- sel_width, dat_width/8, number of byte lanes in wb_sel
- depth_log2, 10, log2 of RAM depth in words
- wait_cycles, 1, wait states inserted before ack; legal range 0..15

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- wb_adr  in  adr_width  byte address
- wb_datwr  in  dat_width  write data
- wb_datrd  out  dat_width  read data; valid while wb_ack is high on a read
- wb_we  in  1  1 = write, 0 = read
- wb_stb  in  1  strobe
- wb_ack  out  1  transfer acknowledge; single-cycle pulse
- wb_cyc  in  1  bus cycle valid
- wb_sel  in  sel_width  byte-lane enables, bit i selects bits [8i+7:8i]

## Operation
- Word index is wb_adr[depth_log2+ob-1:ob], where ob = $clog2(sel_width).
  - wb_adr[ob-1:0] is ignored.
  - Bits above the word index are ignored, so addresses alias modulo depth.
- State machine: IDLE, WAIT, ACK.
- IDLE
  - When wb_cyc & wb_stb is sampled high, latch adr, we, datwr and sel.
  - wait_cycles == 0: go to ACK.
  - Otherwise: load the wait counter with wait_cycles-1 and go to WAIT.
- WAIT
  - If wb_cyc or wb_stb is sampled low, abort: go to IDLE, no RAM access, no ack.
  - Else if the counter is 0, go to ACK.
  - Else decrement the counter.
- Entering ACK, on the same edge:
  - Write: RAM byte lane i is updated only where latched sel[i] = 1.
  - Read: wb_datrd is loaded with the full word, regardless of sel.
- ACK: wb_ack = 1 for exactly one cycle, then unconditional return to IDLE.
- wb_datrd changes only when a read enters ACK; it holds its value otherwise, including through writes.
- RAM contents are not reset. There is no initialisation file.
- Request fields are latched, so master changes after acceptance do not affect the transfer.

## Timing
- Reset values: state IDLE, wb_ack 0, wb_datrd 0, wait counter 0.
- Reset asserted in WAIT or ACK:
  - The next cycle is IDLE with wb_ack = 0.
  - A pending write that has not yet entered ACK is dropped.
- Latency: request sampled at edge E0 makes wb_ack high in the cycle after edge E(wait_cycles). With wait_cycles = 1, the master samples ack at E2.
- Throughput: one transfer per wait_cycles+2 cycles.
  - The cycle after ACK is always IDLE.
  - If the master holds wb_cyc & wb_stb there, the next request is accepted at the following edge.
- wb_ack is registered. It never depends combinationally on any input.
- Read-after-write to the same word, back-to-back: the read returns the new data.
- A write with wb_sel = 0 still acks and leaves memory unchanged.

## Test plan
- Reset, then idle: wb_ack = 0 and wb_datrd = 0 for 10 cycles while wb_cyc = 0.
- Full write then read, wait_cycles = 1:
  - Write 0xDEADBEEF to 0x0000_0010 with sel = 0xF; ack is high exactly in the 2nd cycle after acceptance.
  - Read of 0x10 returns 0xDEADBEEF while ack is high.
- Byte lanes:
  - Write 0x11223344 with sel = 0x5 over a word holding 0xDEADBEEF.
  - Read returns 0xDE22BE44.
  - A write with sel = 0 leaves the word unchanged.
- Aliasing and ignored low bits, depth_log2 = 10:
  - Write 0xA5A5A5A5 to 0x0000_1010.
  - Reads at 0x0000_0010 and 0x0000_0013 both return 0xA5A5A5A5.
- Abort and reset mid-transfer, wait_cycles = 4:
  - Drop wb_cyc in WAIT: no ack, memory unchanged.
  - Assert reset in WAIT: ack stays 0, state is IDLE, memory unchanged.
- Back-to-back, wait_cycles = 0: 8 consecutive requests with stb held high give acks every 2nd cycle, and each read returns the preceding write's data.

Source files
------------

// File: rtl/wb_ram_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_ram_slave_if : Wishbone classic-cycle bus bundle (master/slave views)
// Revision 1.0
// ---------------------------------------------------------------------------
interface wb_ram_slave_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8
);
  logic [ADR_WIDTH-1:0] wb_adr;
  logic [DAT_WIDTH-1:0] wb_datwr;
  logic [DAT_WIDTH-1:0] wb_datrd;
  logic                 wb_we;
  logic                 wb_stb;
  logic                 wb_ack;
  logic                 wb_cyc;
  logic [SEL_WIDTH-1:0] wb_sel;

  modport master (
    output wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
    input  wb_datrd, wb_ack
  );

  modport slave (
    input  wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
    output wb_datrd, wb_ack
  );
endinterface
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_ram_slave : Wishbone classic responder over a byte-lane word RAM
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_ram_slave #(
  parameter int ADR_WIDTH   = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int SEL_WIDTH   = DAT_WIDTH / 8,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clock,
  input  logic           reset,
  wb_ram_slave_if.slave  wb
);

  localparam int          c_ob        = $clog2(SEL_WIDTH);
  localparam int          c_depth     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic                   we_q;
  logic [DAT_WIDTH-1:0]   dat_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   ack_q;
  logic [DAT_WIDTH-1:0]   datrd_q;
  logic [DAT_WIDTH-1:0]   mem_q [0:c_depth-1];

  logic                   w_req;
  logic                   w_from_idle;
  logic                   w_from_wait;
  logic                   w_enter_ack;
  logic [DEPTH_LOG2-1:0]  w_idx_in;
  logic [DEPTH_LOG2-1:0]  w_idx;
  logic                   w_we;
  logic [DAT_WIDTH-1:0]   w_dat;
  logic [SEL_WIDTH-1:0]   w_sel;
  logic [ADR_WIDTH-DEPTH_LOG2-1:0] w_unused_adr;

  assign w_req        = wb.wb_cyc & wb.wb_stb;
  assign w_idx_in     = wb.wb_adr[DEPTH_LOG2+c_ob-1:c_ob];
  assign w_unused_adr = {wb.wb_adr[ADR_WIDTH-1:DEPTH_LOG2+c_ob], wb.wb_adr[c_ob-1:0]};

  // With zero wait states the RAM is accessed on the accepting edge, so the
  // live bus fields are used; otherwise the latched copy drives the access.
  assign w_from_idle  = (state_q == S_IDLE) && w_req && (WAIT_CYCLES == 0);
  assign w_from_wait  = (state_q == S_WAIT) && w_req && (cnt_q == 4'd0);
  assign w_enter_ack  = !reset && (w_from_idle || w_from_wait);
  assign w_idx        = (state_q == S_IDLE) ? w_idx_in       : idx_q;
  assign w_we         = (state_q == S_IDLE) ? wb.wb_we       : we_q;
  assign w_dat        = (state_q == S_IDLE) ? wb.wb_datwr    : dat_q;
  assign w_sel        = (state_q == S_IDLE) ? wb.wb_sel      : sel_q;

  always_ff @(posedge clock) begin
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (w_enter_ack && w_we && w_sel[i]) begin
        mem_q[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      datrd_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (w_enter_ack && !w_we) begin
        datrd_q <= mem_q[w_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            idx_q <= w_idx_in;
            we_q  <= wb.wb_we;
            dat_q <= wb.wb_datwr;
            sel_q <= wb.wb_sel;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else begin
              cnt_q   <= c_wait_load;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_datrd = datrd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_ram_slave : three responders (1, 4 and 0 wait states) on one clock
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb_ram_slave;

  logic        clock = 1'b0;
  logic        rst   [3];
  logic [31:0] adr   [3];
  logic [31:0] datwr [3];
  logic [31:0] datrd [3];
  logic        we    [3];
  logic        stb   [3];
  logic        cyc   [3];
  logic        ack   [3];
  logic [3:0]  sel   [3];

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rd [3];

  typedef struct {
    logic        we;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int W = (k == 0) ? 1 : ((k == 1) ? 4 : 0);
    wb_ram_slave_if #(.ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4)) bus ();
    assign bus.wb_adr   = adr[k];
    assign bus.wb_datwr = datwr[k];
    assign bus.wb_we    = we[k];
    assign bus.wb_stb   = stb[k];
    assign bus.wb_cyc   = cyc[k];
    assign bus.wb_sel   = sel[k];
    assign datrd[k]     = bus.wb_datrd;
    assign ack[k]       = bus.wb_ack;
    wb_ram_slave #(
      .ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4),
      .DEPTH_LOG2(10), .WAIT_CYCLES(W)
    ) u_dut (
      .clock (clock),
      .reset (rst[k]),
      .wb    (bus.slave)
    );
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int k, input int budget, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clock);
      #1;
      n++;
      if (ack[k]) got = 1'b1;
    end
  endtask

  task automatic do_xfer(input int k, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] e);
    int  n;
    bit  got;
    sb_t item;
    adr[k] = a; we[k] = w; datwr[k] = d; sel[k] = s; cyc[k] = 1'b1; stb[k] = 1'b1;
    sbq.push_back('{we: w, exp: e});
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clock);
      #1;
      n++;
      if (ack[k]) got = 1'b1;
      else if (n == 1) begin
        // request was accepted; scramble the bus to prove fields are latched
        adr[k] = ~a; datwr[k] = ~d; sel[k] = ~s; we[k] = ~w;
      end
    end
    item = sbq.pop_front();
    if (!got) begin
      check("ack_timeout", 32'(n), 32'd0);
    end else begin
      check("ack_latency", 32'(n), 32'(wait_of(k) + 1));
      if (item.we) begin
        check("datrd_hold_on_write", datrd[k], last_rd[k]);
      end else begin
        check("read_data", datrd[k], item.exp);
        last_rd[k] = item.exp;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clock);
    #1;
    check("ack_single_pulse", 32'(ack[k]), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int  n;
    bit  got;
    bit  seen;
    sb_t item;

    vecs[0] = '{a: 32'h0000_0010, w: 1'b1, d: 32'hDEAD_BEEF, s: 4'hF, e: 32'h0};
    vecs[1] = '{a: 32'h0000_0010, w: 1'b0, d: 32'h0,         s: 4'hF, e: 32'hDEAD_BEEF};
    vecs[2] = '{a: 32'h0000_0010, w: 1'b1, d: 32'h1122_3344, s: 4'h5, e: 32'h0};
    vecs[3] = '{a: 32'h0000_0010, w: 1'b0, d: 32'h0,         s: 4'h0, e: 32'hDE22_BE44};
    vecs[4] = '{a: 32'h0000_0010, w: 1'b1, d: 32'hFFFF_FFFF, s: 4'h0, e: 32'h0};
    vecs[5] = '{a: 32'h0000_0010, w: 1'b0, d: 32'h0,         s: 4'hF, e: 32'hDE22_BE44};
    vecs[6] = '{a: 32'h0000_1010, w: 1'b1, d: 32'hA5A5_A5A5, s: 4'hF, e: 32'h0};
    vecs[7] = '{a: 32'h0000_0010, w: 1'b0, d: 32'h0,         s: 4'hF, e: 32'hA5A5_A5A5};
    vecs[8] = '{a: 32'h0000_0013, w: 1'b0, d: 32'h0,         s: 4'h1, e: 32'hA5A5_A5A5};
    vecs[9] = '{a: 32'hFFFF_F010, w: 1'b0, d: 32'h0,         s: 4'hF, e: 32'hA5A5_A5A5};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; adr[k] = '0; datwr[k] = '0; we[k] = 1'b0;
      stb[k] = 1'b0; cyc[k] = 1'b0; sel[k] = '0; last_rd[k] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        check("reset_ack", 32'(ack[k]), 32'd0);
        check("reset_datrd", datrd[k], 32'd0);
      end
    end

    // table-driven transfers on the one-wait-state responder
    foreach (vecs[i]) do_xfer(0, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].s, vecs[i].e);

    // abort and reset during WAIT on the four-wait-state responder
    do_xfer(1, 32'h0000_0020, 1'b1, 32'h0123_4567, 4'hF, 32'h0);
    adr[1] = 32'h20; we[1] = 1'b1; datwr[1] = 32'hFFFF_FFFF; sel[1] = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("abort_pre_ack", 32'(ack[1]), 32'd0);
    cyc[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (ack[1]) seen = 1'b1;
    end
    stb[1] = 1'b0;
    check("abort_no_ack", 32'(seen), 32'd0);
    do_xfer(1, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 32'h0123_4567);

    adr[1] = 32'h20; we[1] = 1'b1; datwr[1] = 32'hFFFF_FFFF; sel[1] = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clock);
    #1;
    rst[1] = 1'b0;
    check("reset_mid_ack", 32'(ack[1]), 32'd0);
    check("reset_mid_datrd", datrd[1], 32'd0);
    last_rd[1] = 32'd0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (ack[1]) seen = 1'b1;
    end
    check("reset_mid_no_ack", 32'(seen), 32'd0);
    do_xfer(1, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 32'h0123_4567);

    // back-to-back on the zero-wait responder, strobe held throughout
    cyc[2] = 1'b1; stb[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adr[2]   = 32'h40 + 32'((i / 2) * 4);
      we[2]    = (i % 2 == 0);
      datwr[2] = (i % 2 == 0) ? 32'h5A00_0000 + 32'(i) : 32'h0;
      sel[2]   = 4'hF;
      sbq.push_back('{we: we[2], exp: 32'h5A00_0000 + 32'(i - (i % 2))});
      wait_ack(2, 20, n, got);
      item = sbq.pop_front();
      if (!got) begin
        check("b2b_timeout", 32'(n), 32'd0);
      end else begin
        check("b2b_spacing", 32'(n), (i == 0) ? 32'd1 : 32'd2);
        if (!item.we) check("b2b_read", datrd[2], item.exp);
      end
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clock);
    #1;
    check("b2b_end_ack", 32'(ack[2]), 32'd0);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
